// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - 8-bit bit-serial subtractor, LSB first, with borrow/overflow/zero/negative flags
module serial_subtractor (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       BI,
    output logic [7:0] Y,
    output logic       C,
    output logic       V,
    output logic       Z,
    output logic       N,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] res_q, res_d;
    logic       br_q, br_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       c_q, c_d;
    logic       v_q, v_d;
    logic       z_q, z_d;
    logic       n_q, n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       diff_bit;
    logic       br_next;
    logic [7:0] res_shift;

    always_comb begin
        diff_bit  = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = {diff_bit, res_q[7:1]};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = BI;
                    res_d   = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + 3'd1;
                // Last bit: br_q is the borrow into bit 7, br_next the borrow out of it.
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    y_d     = res_shift;
                    c_d     = br_next;
                    v_d     = br_q ^ br_next;
                    z_d     = (res_shift == 8'h00);
                    n_d     = diff_bit;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            br_q    <= 1'b0;
            cnt_q   <= 3'd0;
            y_q     <= 8'h00;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y    = y_q;
    assign C    = c_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have no parameters; the operand width is fixed at 8 bits.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a subtraction; sampled only in IDLE or DONE.
REQ-006 A  input  8  minuend; captured on the accepted start edge.
REQ-007 B  input  8  subtrahend; captured on the accepted start edge.
REQ-008 BI  input  1  borrow-in; captured on the accepted start edge.
REQ-009 Y  output  8  difference, A - B - BI mod 256.
REQ-010 C  output  1  borrow-out; 1 when A < B + BI, unsigned.
REQ-011 V  output  1  signed overflow.
REQ-012 Z  output  1  1 when Y == 0x00.
REQ-013 N  output  1  copy of Y[7].
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse high in DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE with start=1: the block SHALL capture A, B and BI into shift/borrow registers, clear the 3-bit bit counter, and go to RUN.
REQ-018 RUN processing:
- one bit per clock, LSB first;
- the block SHALL use a single 1-bit full subtractor: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br);
- the difference bit SHALL shift into the result register from the MSB side.
REQ-019 RUN SHALL last exactly 8 clocks (counter values 0..7); after the counter-7 edge the state SHALL be DONE.
REQ-020 On the RUN-to-DONE edge, Y, C, V, Z and N SHALL update together:
- C = final borrow;
- V = borrow into bit 7 XOR borrow out of bit 7;
- Z and N SHALL be computed from the final Y.
REQ-021 Y, C, V, Z and N SHALL hold their values at all times except on the RUN-to-DONE edge and on reset.
REQ-022 Latency: start is accepted at edge k; done SHALL be high in the cycle after edge k+8 and low after edge k+9.
REQ-023 DONE SHALL last one cycle:
- start=0 in DONE: the block SHALL go to IDLE;
- start=1 in DONE: the block SHALL capture new operands and go directly to RUN (back-to-back, with no dead cycle).
REQ-024 start while in RUN SHALL be ignored; the captured operands and the counter SHALL NOT change.
REQ-025 Changes on A, B or BI after the accepted start edge SHALL NOT affect the result.
REQ-026 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; the two SHALL never be high together.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL enter IDLE and clear all outputs: Y=0x00, C=0, V=0, Z=0, N=0, busy=0, done=0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset in RUN or DONE SHALL abort the operation with no done pulse; the aborted result SHALL never appear on Y.
REQ-030 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-031 The bench SHALL apply A=0x05, B=0x03, BI=0, start for 1 cycle -> busy for 8 cycles, then done pulse with Y=0x02, C=0, V=0, Z=0, N=0.
REQ-032 The bench SHALL apply A=0x00, B=0x01, BI=0 -> Y=0xFF, C=1, V=0, Z=0, N=1.
REQ-033 The bench SHALL apply A=0x80, B=0x01, BI=0 and then A=0x7F, B=0xFF, BI=0 -> first result Y=0x7F, C=0, V=1; second result Y=0x80, C=1, V=1, N=1.
REQ-034 The bench SHALL apply A=0x10, B=0x0F, BI=1 -> Y=0x00, Z=1, C=0, V=0.
REQ-035 The bench SHALL start 0x05-0x03, change A/B and pulse start mid-RUN, then assert start in the DONE cycle with A=0x09, B=0x04 -> first result 0x02 (mid-RUN start ignored), then busy asserted in the following cycle and the next done pulse 9 cycles after the first with Y=0x05.
REQ-036 The bench SHALL assert reset at RUN counter 4 -> next cycle busy=0, done=0, Y=0x00, all flags 0; no done pulse SHALL follow.
